// File: rtl/vid_timing.sv
// Video framing stage: turns the retimed pixel stream plus blanking levels into
// coordinate-tagged pixels, boundary strobes, geometry measurements and sticky error flags.
module vid_timing #(
    parameter int EXP_WIDTH  = 320,
    parameter int EXP_HEIGHT = 256,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   vid_pixel,
    input  logic          vid_pixsync,
    input  logic          vid_hblank,
    input  logic          vid_vblank,
    input  logic          err_clear,
    output logic [11:0]   out_pixel,
    output logic          out_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          frame_start,
    output logic          frame_end,
    output logic          line_end,
    output logic [CW-1:0] last_width,
    output logic [CW-1:0] last_height,
    output logic [31:0]   frame_count,
    output logic          err_width,
    output logic          err_height,
    output logic          err_ovf
);

    localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] EXP_W = CW'(EXP_WIDTH);
    localparam logic [CW-1:0] EXP_H = CW'(EXP_HEIGHT);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_VBLANK,
        ST_HBLANK,
        ST_LINE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_hb_q;
    logic          r_vb_q;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    logic [11:0]   r_out_pixel;
    logic          r_out_valid;
    logic [CW-1:0] r_out_x;
    logic [CW-1:0] r_out_y;
    logic          r_frame_start;
    logic          r_frame_end;
    logic          r_line_end;
    logic [CW-1:0] r_last_width;
    logic [CW-1:0] r_last_height;
    logic [31:0]   r_frame_count;
    logic          r_err_width;
    logic          r_err_height;
    logic          r_err_ovf;

    logic          w_hb_rise;
    logic          w_hb_fall;
    logic          w_vb_rise;
    logic          w_vb_fall;
    logic          w_accept;
    logic          w_start_frame;
    logic          w_start_line;
    logic          w_close_line;
    logic          w_close_frame;
    logic [CW-1:0] w_pix_x;
    logic          w_x_sat;
    logic [CW-1:0] w_x_next;
    logic          w_y_sat;
    logic [CW-1:0] w_y_next;
    logic [CW-1:0] w_height;
    logic          w_set_width;
    logic          w_set_height;
    logic          w_set_ovf;

    assign w_hb_rise = vid_hblank & ~r_hb_q;
    assign w_hb_fall = ~vid_hblank & r_hb_q;
    assign w_vb_rise = vid_vblank & ~r_vb_q;
    assign w_vb_fall = ~vid_vblank & r_vb_q;

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_start_frame = 1'b0;
        w_start_line  = 1'b0;
        w_close_line  = 1'b0;
        w_close_frame = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (vid_vblank) begin
                    w_next_state = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (w_vb_fall) begin
                    w_start_frame = 1'b1;
                    w_next_state  = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (w_vb_rise) begin
                    w_close_frame = 1'b1;
                    w_next_state  = ST_VBLANK;
                end else if (w_hb_fall && !vid_vblank) begin
                    // a pixel arriving with the hblank fall is the first pixel of the line
                    w_start_line = 1'b1;
                    w_accept     = vid_pixsync;
                    w_next_state = ST_LINE;
                end
            end
            ST_LINE: begin
                w_accept = vid_pixsync & ~vid_hblank & ~vid_vblank;
                if (w_vb_rise) begin
                    w_close_line  = 1'b1;
                    w_close_frame = 1'b1;
                    w_next_state  = ST_VBLANK;
                end else if (w_hb_rise) begin
                    w_close_line = 1'b1;
                    w_next_state = ST_HBLANK;
                end
            end
            default: begin
                w_next_state = ST_SYNC;
            end
        endcase
    end

    assign w_pix_x  = w_start_line ? '0 : r_x;
    assign w_x_sat  = (w_pix_x == CMAX);
    assign w_x_next = w_x_sat ? w_pix_x : w_pix_x + ONE;
    assign w_y_sat  = (r_y == CMAX);
    assign w_y_next = w_y_sat ? r_y : r_y + ONE;

    // a frame closing from LINE also counts the line closed in the same cycle
    assign w_height     = w_close_line ? w_y_next : r_y;
    assign w_set_width  = w_close_line && (r_x != EXP_W);
    assign w_set_height = w_close_frame && (w_height != EXP_H);
    assign w_set_ovf    = (w_accept && w_x_sat) || (w_close_line && w_y_sat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SYNC;
            r_hb_q  <= 1'b0;
            r_vb_q  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next_state;
            r_hb_q  <= vid_hblank;
            r_vb_q  <= vid_vblank;
            if (w_accept) begin
                r_x <= w_x_next;
            end else if (w_start_line) begin
                r_x <= '0;
            end
            if (w_start_frame) begin
                r_y <= '0;
            end else if (w_close_line) begin
                r_y <= w_y_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_pixel   <= '0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            r_out_valid   <= w_accept;
            r_frame_start <= w_start_frame;
            r_frame_end   <= w_close_frame;
            r_line_end    <= w_close_line;
            if (w_accept) begin
                r_out_pixel <= vid_pixel;
                r_out_x     <= w_pix_x;
                r_out_y     <= r_y;
            end
        end
    end

    // error flags: a set in the same cycle as err_clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_width  <= '0;
            r_last_height <= '0;
            r_frame_count <= '0;
            r_err_width   <= 1'b0;
            r_err_height  <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            if (w_close_line) begin
                r_last_width <= r_x;
            end
            if (w_close_frame) begin
                r_last_height <= w_height;
                r_frame_count <= r_frame_count + 32'd1;
            end
            r_err_width  <= (r_err_width  & ~err_clear) | w_set_width;
            r_err_height <= (r_err_height & ~err_clear) | w_set_height;
            r_err_ovf    <= (r_err_ovf    & ~err_clear) | w_set_ovf;
        end
    end

    assign out_pixel   = r_out_pixel;
    assign out_valid   = r_out_valid;
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign line_end    = r_line_end;
    assign last_width  = r_last_width;
    assign last_height = r_last_height;
    assign frame_count = r_frame_count;
    assign err_width   = r_err_width;
    assign err_height  = r_err_height;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_vid_timing.sv
// Directed bench for vid_timing with reduced geometry (20x6, CW=7) so that
// saturation and long frames stay short; expected values are hand-derived.
module tb_vid_timing;

    localparam int EXP_W = 20;
    localparam int EXP_H = 6;
    localparam int CW    = 7;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic [11:0]   vidPixel;
    logic          vidPixsync;
    logic          vidHblank;
    logic          vidVblank;
    logic          errClear;
    logic [11:0]   outPixel;
    logic          outValid;
    logic [CW-1:0] outX;
    logic [CW-1:0] outY;
    logic          frameStart;
    logic          frameEnd;
    logic          lineEnd;
    logic [CW-1:0] lastWidth;
    logic [CW-1:0] lastHeight;
    logic [31:0]   frameCount;
    logic          errWidth;
    logic          errHeight;
    logic          errOvf;

    int checkCount      = 0;
    int errorCount      = 0;
    int validCount      = 0;
    int lineEndCount    = 0;
    int frameEndCount   = 0;
    int frameStartCount = 0;
    int bothCount       = 0;
    int baseValid;
    int baseLine;
    int baseFrame;
    int baseStart;
    int baseBoth;

    vid_timing #(
        .EXP_WIDTH (EXP_W),
        .EXP_HEIGHT(EXP_H),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rstN),
        .vid_pixel  (vidPixel),
        .vid_pixsync(vidPixsync),
        .vid_hblank (vidHblank),
        .vid_vblank (vidVblank),
        .err_clear  (errClear),
        .out_pixel  (outPixel),
        .out_valid  (outValid),
        .out_x      (outX),
        .out_y      (outY),
        .frame_start(frameStart),
        .frame_end  (frameEnd),
        .line_end   (lineEnd),
        .last_width (lastWidth),
        .last_height(lastHeight),
        .frame_count(frameCount),
        .err_width  (errWidth),
        .err_height (errHeight),
        .err_ovf    (errOvf)
    );

    always #10 clk = ~clk;

    // pulse counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (outValid) validCount++;
        if (lineEnd) lineEndCount++;
        if (frameEnd) frameEndCount++;
        if (frameStart) frameStartCount++;
        if (lineEnd && frameEnd) bothCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // drive one clock cycle of inputs; returns 1 ns after the edge that sampled them
    task automatic applyStimulus(input logic sync, input logic hb, input logic vb,
                                 input logic [11:0] pix, input logic clr);
        vidPixsync = sync;
        vidHblank  = hb;
        vidVblank  = vb;
        vidPixel   = pix;
        errClear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame();
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 12'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        checkOutput("frameStart", 64'(frameStart), 64'd1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
    endtask

    task automatic endFrame();
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd0, 1'b0);
        checkOutput("frameEnd", 64'(frameEnd), 64'd1);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 12'd0, 1'b0);
    endtask

    task automatic clearErrors();
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd0, 1'b1);
        checkOutput("errCleared", {61'd0, errWidth, errHeight, errOvf}, 64'd0);
    endtask

    // one active line; the first pixel rides on the hblank fall, the line ends
    // with an hblank rise or (endOnVblank) a vblank rise
    task automatic sendLine(input int lineNo, input int nPix, input int clkPerPix,
                            input logic endOnVblank, input logic syncOnEnd,
                            input logic clrOnEnd, input logic expectOut);
        logic [11:0] pix;
        int          xExp;
        for (int k = 0; k < nPix; k++) begin
            pix  = {5'(lineNo), 7'(k)};
            xExp = (k > MAXC) ? MAXC : k;
            for (int c = 0; c < clkPerPix; c++) begin
                applyStimulus(c == 0, 1'b0, 1'b0, pix, 1'b0);
                if (c == 0) begin
                    if (expectOut)
                        checkOutput("pixel", {31'd0, outValid, outPixel, 10'(outY), 10'(outX)},
                                    {31'd0, 1'b1, pix, 10'(lineNo), 10'(xExp)});
                    else
                        checkOutput("noPixel", 64'(outValid), 64'd0);
                end
            end
        end
        applyStimulus(syncOnEnd, !endOnVblank, endOnVblank, {5'(lineNo), 7'(nPix)}, clrOnEnd);
        checkOutput("endDrop", 64'(outValid), 64'd0);
        checkOutput("lineEnd", 64'(lineEnd), 64'(expectOut));
        repeat (3) applyStimulus(1'b0, 1'b1, endOnVblank, 12'd0, 1'b0);
    endtask

    task automatic takeBase();
        baseValid = validCount;
        baseLine  = lineEndCount;
        baseFrame = frameEndCount;
        baseStart = frameStartCount;
        baseBoth  = bothCount;
    endtask

    initial begin
        rstN       = 1'b0;
        vidPixel   = 12'd0;
        vidPixsync = 1'b0;
        vidHblank  = 1'b1;
        vidVblank  = 1'b0;
        errClear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        checkOutput("rstPulses", {60'd0, outValid, frameStart, frameEnd, lineEnd}, 64'd0);
        checkOutput("rstPix", {31'd0, outPixel, 10'(outX), 10'(outY)}, 64'd0);
        checkOutput("rstGeom", {44'd0, 10'(lastWidth), 10'(lastHeight)}, 64'd0);
        checkOutput("rstCount", 64'(frameCount), 64'd0);
        checkOutput("rstErr", {61'd0, errWidth, errHeight, errOvf}, 64'd0);

        // released mid-frame: nothing may come out until a vblank and its fall
        rstN = 1'b1;
        takeBase();
        sendLine(3, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendLine(4, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("syncValid", 64'(validCount - baseValid), 64'd0);
        checkOutput("syncPulses", 64'(lineEndCount - baseLine + frameStartCount - baseStart
                                      + frameEndCount - baseFrame), 64'd0);

        // nominal frame, two clocks per pixel
        takeBase();
        startFrame();
        for (int l = 0; l < EXP_H; l++) sendLine(l, EXP_W, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        endFrame();
        checkOutput("nomValid", 64'(validCount - baseValid), 64'(EXP_W * EXP_H));
        checkOutput("nomLines", 64'(lineEndCount - baseLine), 64'(EXP_H));
        checkOutput("nomFrames", 64'(frameEndCount - baseFrame), 64'd1);
        checkOutput("nomLastXY", {44'd0, 10'(outX), 10'(outY)}, {44'd0, 10'd19, 10'd5});
        checkOutput("nomGeom", {44'd0, 10'(lastWidth), 10'(lastHeight)}, {44'd0, 10'd20, 10'd6});
        checkOutput("nomCount", 64'(frameCount), 64'd1);
        checkOutput("nomErr", {61'd0, errWidth, errHeight, errOvf}, 64'd0);

        // width errors, clear, and clear colliding with a new error
        startFrame();
        sendLine(0, 19, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("shortWidth", 64'(lastWidth), 64'd19);
        checkOutput("shortErr", 64'(errWidth), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        checkOutput("widthClear", 64'(errWidth), 64'd0);
        sendLine(1, 21, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("longWidth", 64'(lastWidth), 64'd21);
        checkOutput("setWinsClear", 64'(errWidth), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        checkOutput("widthClear2", 64'(errWidth), 64'd0);
        for (int l = 2; l < EXP_H; l++) sendLine(l, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        endFrame();
        checkOutput("f2Err", {61'd0, errWidth, errHeight, errOvf}, 64'd0);
        checkOutput("f2Count", 64'(frameCount), 64'd2);

        // vblank rises inside the 101st line
        takeBase();
        startFrame();
        for (int l = 0; l < 100; l++) sendLine(l, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendLine(100, EXP_W, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("vbLineEnds", 64'(lineEndCount - baseLine), 64'd101);
        checkOutput("vbFrameEnds", 64'(frameEndCount - baseFrame), 64'd1);
        checkOutput("vbSameCycle", 64'(bothCount - baseBoth), 64'd1);
        checkOutput("vbHeight", 64'(lastHeight), 64'd101);
        checkOutput("vbErrH", {62'd0, errHeight, errWidth}, {62'd0, 1'b1, 1'b0});
        checkOutput("vbCount", 64'(frameCount), 64'd3);
        clearErrors();

        // 140-pixel line saturates x at 127; pixel on the hblank rise is dropped
        takeBase();
        startFrame();
        sendLine(0, 140, 1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ovfValid", 64'(validCount - baseValid), 64'd140);
        checkOutput("ovfX", 64'(outX), 64'(MAXC));
        checkOutput("ovfWidth", 64'(lastWidth), 64'(MAXC));
        checkOutput("ovfErr", 64'(errOvf), 64'd1);
        endFrame();
        checkOutput("ovfHeight", {62'd0, 1'(lastHeight == 1), errHeight}, 64'd3);
        clearErrors();

        // frame_count wraps from all-ones
        startFrame();
        force dut.r_frame_count = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        release dut.r_frame_count;
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        checkOutput("preload", 64'(frameCount), 64'hFFFF_FFFF);
        for (int l = 0; l < EXP_H; l++) sendLine(l, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        endFrame();
        checkOutput("wrapCount", 64'(frameCount), 64'd0);
        checkOutput("wrapErr", {61'd0, errWidth, errHeight, errOvf}, 64'd0);

        // reset asserted mid-line clears state immediately, capture waits for vblank
        startFrame();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 12'(k), 1'b0);
        checkOutput("preRstX", 64'(outX), 64'd4);
        rstN = 1'b0;
        #2;
        checkOutput("midRstOut", {44'd0, 1'(outValid), 10'(outX), 9'(lastHeight)}, 64'd0);
        checkOutput("midRstGeom", 64'(lastWidth), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        rstN = 1'b1;
        takeBase();
        sendLine(0, EXP_W, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postRstValid", 64'(validCount - baseValid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
